// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator output writer: the job state
// encoding and the widths of the shift-amount and job-size control fields.
// No ports; imported by acc_out_writer_if and acc_out_writer.
// ----------------------------------------------------------------------------
package acc_pkg;

   // Width of the right-shift amount applied to every lane.
   localparam int SHIFT_W = 5;

   // Width of the beat count of one job.
   localparam int SIZE_W = 11;

   // Job sequencing states of the writer.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } accState_t;

endpackage

// File: rtl/acc_out_writer_if.sv
// ----------------------------------------------------------------------------
// acc_out_writer_if
// Bundles every non-clock signal of the accumulator output writer:
//   control : start, base, size, shift
//   stream  : s_sum, s_valid, s_first, s_last, s_ready
//   write   : w_en, w_addr, w_data, w_ready
//   status  : busy, done, err
// Modport slave is the writer's own view; modport master is the view of the
// surrounding logic that launches jobs, feeds beats and owns the RAM.
// ----------------------------------------------------------------------------
interface acc_out_writer_if
   import acc_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 22,
   parameter int DN = 1,
   parameter int OW = 8
);

   logic                 start;
   logic [AW-1:0]        base;
   logic [SIZE_W-1:0]    size;
   logic [SHIFT_W-1:0]   shift;

   logic [DW*DN-1:0]     s_sum;
   logic                 s_valid;
   logic                 s_first;
   logic                 s_last;
   logic                 s_ready;

   logic                 w_en;
   logic [AW-1:0]        w_addr;
   logic [OW*DN-1:0]     w_data;
   logic                 w_ready;

   logic                 busy;
   logic                 done;
   logic                 err;

   modport slave (
      input  start, base, size, shift,
      input  s_sum, s_valid, s_first, s_last,
      output s_ready,
      output w_en, w_addr, w_data,
      input  w_ready,
      output busy, done, err
   );

   modport master (
      output start, base, size, shift,
      output s_sum, s_valid, s_first, s_last,
      input  s_ready,
      input  w_en, w_addr, w_data,
      output w_ready,
      input  busy, done, err
   );

endinterface

// File: rtl/acc_skid_fifo.sv
// ----------------------------------------------------------------------------
// acc_skid_fifo
// Small synchronous FIFO that absorbs accumulator beats while the RAM write
// port is stalled. Depth D must be a power of two so the pointers wrap
// naturally.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (empties the FIFO)
//   i_wrEn       push request, i_wrData pushed word
//   i_rdEn       pop request, o_rdData head word (valid when !o_empty)
//   o_full       no free entry, o_empty no stored entry
// ----------------------------------------------------------------------------
module acc_skid_fifo #(
   parameter int W = 22,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_wrEn,
   input  logic [W-1:0] i_wrData,
   input  logic         i_rdEn,
   output logic [W-1:0] o_rdData,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PW = (D > 1) ? $clog2(D) : 1;

   logic [W-1:0]  r_mem [D];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [PW:0]   r_count;
   logic          w_doWrite;
   logic          w_doRead;

   assign o_full   = (r_count == (PW+1)'(D));
   assign o_empty  = (r_count == '0);
   assign o_rdData = r_mem[r_rdPtr];

   // A push into a full FIFO is still taken when a pop frees the head slot
   // in the same cycle, so the occupancy stays unchanged instead of dropping.
   assign w_doRead  = i_rdEn && !o_empty;
   assign w_doWrite = i_wrEn && (!o_full || w_doRead);

   // Storage array has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_doWrite) begin
         r_mem[r_wrPtr] <= i_wrData;
      end
   end

   // Pointer and occupancy bookkeeping; reset empties the FIFO at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doWrite) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doRead) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_doWrite, w_doRead})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/acc_out_writer.sv
// ----------------------------------------------------------------------------
// acc_out_writer
// Takes a job (base address, beat count, shift) and a stream of accumulator
// beats, quantises every lane (rounding arithmetic right shift followed by
// signed saturation to OW bits) and writes the beats to consecutive RAM
// addresses starting at base, wrapping modulo 2^AW. Beats are buffered in a
// skid FIFO so the RAM may stall the write port. Framing violations and
// beats arriving outside a job set a sticky error flag.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, aborts any job in progress
//   io_bus  acc_out_writer_if.slave: control, stream, write and status
// Build option:
//   ACC_OUT_RELU_EN  when defined, negative lane results are clamped to zero
//                    before saturation.
// ----------------------------------------------------------------------------
module acc_out_writer
   import acc_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 22,
   parameter int DN = 1,
   parameter int OW = 8,
   parameter int FD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   acc_out_writer_if.slave   io_bus
);

   // Saturation bounds in the widened lane domain and in the output domain.
   localparam logic signed [DW:0] SAT_MAX = $signed({{(DW+2-OW){1'b0}}, {(OW-1){1'b1}}});
   localparam logic signed [DW:0] SAT_MIN = ~SAT_MAX;
   localparam logic [OW-1:0]      OUT_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0]      OUT_MIN = {1'b1, {(OW-1){1'b0}}};

   accState_t            r_state;
   accState_t            w_nextState;

   logic [AW-1:0]        r_base;
   logic [SIZE_W-1:0]    r_size;
   logic [SHIFT_W-1:0]   r_shift;
   logic [SIZE_W-1:0]    r_beatCnt;
   logic [AW-1:0]        r_wrIdx;
   logic                 r_err;

   logic                 r_wEn;
   logic [AW-1:0]        r_wAddr;
   logic [OW*DN-1:0]     r_wData;

   logic                 w_sReady;
   logic                 w_accept;
   logic                 w_startAcc;
   logic                 w_lastBeat;
   logic                 w_drop;
   logic                 w_frameErr;
   logic                 w_pop;
   logic                 w_writeDone;
   logic                 w_busy;
   logic                 w_done;

   logic [DW*DN-1:0]     w_fifoData;
   logic                 w_fifoFull;
   logic                 w_fifoEmpty;
   logic [OW*DN-1:0]     w_quant;

   // Handshake and job-event decode shared by the FSM and the datapath.
   assign w_sReady    = (r_state == RUN) && !w_fifoFull;
   assign w_accept    = io_bus.s_valid && w_sReady;
   assign w_startAcc  = (r_state == IDLE) && io_bus.start;
   assign w_lastBeat  = (r_beatCnt == (r_size - SIZE_W'(1)));
   assign w_drop      = io_bus.s_valid && (r_state != RUN);
   assign w_frameErr  = w_accept &&
                        ((io_bus.s_first != (r_beatCnt == '0)) ||
                         (io_bus.s_last  != w_lastBeat));
   assign w_pop       = !w_fifoEmpty && (!r_wEn || io_bus.w_ready);
   assign w_writeDone = r_wEn && io_bus.w_ready;

   acc_skid_fifo #(
      .W (DW*DN),
      .D (FD)
   ) uFifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wrEn   (w_accept),
      .i_wrData (io_bus.s_sum),
      .i_rdEn   (w_pop),
      .o_rdData (w_fifoData),
      .o_full   (w_fifoFull),
      .o_empty  (w_fifoEmpty)
   );

   // Per-lane quantiser working on the FIFO head. The sum is widened by one
   // bit so adding the half-LSB rounding constant can never overflow; the
   // arithmetic shift then floors, which together gives round-half-up.
   for (genvar g = 0; g < DN; g++) begin : gLane
      logic signed [DW:0] w_ext;
      logic signed [DW:0] w_rnd;
      logic signed [DW:0] w_shifted;
      logic signed [DW:0] w_clip;
      logic [OW-1:0]      w_laneOut;

      always_comb begin
         w_ext = $signed({w_fifoData[g*DW + DW - 1], w_fifoData[g*DW +: DW]});
         w_rnd = '0;
         if (r_shift != '0) begin
            w_rnd = $signed((DW+1)'(1) << (r_shift - SHIFT_W'(1)));
         end
         w_shifted = (w_ext + w_rnd) >>> r_shift;
         w_clip    = w_shifted;
`ifdef ACC_OUT_RELU_EN
         if (w_shifted[DW]) begin
            w_clip = '0;
         end
`endif
         if (w_clip > SAT_MAX) begin
            w_laneOut = OUT_MAX;
         end else if (w_clip < SAT_MIN) begin
            w_laneOut = OUT_MIN;
         end else begin
            w_laneOut = w_clip[OW-1:0];
         end
      end

      assign w_quant[g*OW +: OW] = w_laneOut;
   end

   // State register for the job sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and status decode. A zero-length job skips straight to the
   // completion pulse; DRAIN waits until the FIFO is empty and the final
   // buffered write has been taken by the RAM.
   always_comb begin
      w_nextState = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (io_bus.start) begin
               w_nextState = (io_bus.size == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            if (w_accept && w_lastBeat) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            w_busy = 1'b1;
            if (w_fifoEmpty && w_writeDone) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Job parameters are captured only when a start is taken in IDLE, so a
   // start pulse during a running job has no effect. The beat counter gives
   // the index used for framing checks and the end-of-job detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base    <= '0;
         r_size    <= '0;
         r_shift   <= '0;
         r_beatCnt <= '0;
      end else if (w_startAcc) begin
         r_base    <= io_bus.base;
         r_size    <= io_bus.size;
         r_shift   <= io_bus.shift;
         r_beatCnt <= '0;
      end else if (w_accept) begin
         r_beatCnt <= r_beatCnt + SIZE_W'(1);
      end
   end

   // Sticky error: cleared by a taken start (which has priority), set by any
   // framing violation or by a beat offered while no job can accept it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_startAcc) begin
         r_err <= 1'b0;
      end else if (w_drop || w_frameErr) begin
         r_err <= 1'b1;
      end
   end

   // Write port register stage. A new beat is loaded whenever the stage is
   // empty or its current write is being accepted; otherwise enable,
   // address and data hold still for the stalled RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wEn   <= 1'b0;
         r_wAddr <= '0;
         r_wData <= '0;
         r_wrIdx <= '0;
      end else begin
         if (w_startAcc) begin
            r_wrIdx <= '0;
         end else if (w_pop) begin
            r_wrIdx <= r_wrIdx + AW'(1);
         end
         if (w_pop) begin
            r_wEn   <= 1'b1;
            r_wAddr <= r_base + r_wrIdx;
            r_wData <= w_quant;
         end else if (w_writeDone) begin
            r_wEn   <= 1'b0;
         end
      end
   end

   assign io_bus.s_ready = w_sReady;
   assign io_bus.w_en    = r_wEn;
   assign io_bus.w_addr  = r_wAddr;
   assign io_bus.w_data  = r_wData;
   assign io_bus.busy    = w_busy;
   assign io_bus.done    = w_done;
   assign io_bus.err     = r_err;

endmodule

// File: tb/tb_acc_out_writer.sv
// ----------------------------------------------------------------------------
// tb_acc_out_writer
// Directed jobs against acc_out_writer with a behavioural model of the
// expected RAM writes (quantised beats at base + index) checked on every
// accepted write, plus literal expectations for the reference jobs.
// ----------------------------------------------------------------------------
module tb_acc_out_writer;

   logic clk;
   logic rst_n;

   acc_out_writer_if #(.AW(8), .DW(22), .DN(1), .OW(8)) bus ();

   acc_out_writer #(.AW(8), .DW(22), .DN(1), .OW(8), .FD(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } expT;

   int          checkCnt = 0;
   int          passCnt  = 0;

   // model state, owned by the monitor process
   expT         expQ[$];
   logic [7:0]  obsAddr[$];
   logic [7:0]  obsData[$];
   logic [7:0]  mBase = '0;
   int          mShift = 0;
   logic [7:0]  mIdx = '0;
   int          jobAcc = 0;
   int          firstStallAcc = -1;
   int          doneCnt = 0;
   int          wrCnt = 0;
   bit          prevStall = 0;
   logic [7:0]  prevAddr = '0;
   logic [7:0]  prevData = '0;

   // stimulus state, owned by the driver process
   logic [21:0] stimSum[16];
   bit          stimFirst[16];
   bit          stimLast[16];
   int          stallLeft = 0;
   int          lastLat = 0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute bound so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against the expected one.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act === exp) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference quantiser: round-half-up right shift, optional ReLU, clamp to int8.
   function automatic logic [7:0] quantModel(input logic [21:0] raw, input int sh);
      longint v;
      v = longint'($signed(raw));
      if (sh > 0) begin
         v = (v + (longint'(1) << (sh - 1))) >>> sh;
      end
`ifdef ACC_OUT_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   // Monitor and scoreboard: learns each job from the start it sees in IDLE,
   // predicts one write per accepted beat, and checks every accepted write.
   always @(negedge clk) begin
      expT e;
      if (!rst_n) begin
         expQ.delete();
         prevStall = 0;
      end else begin
         if (prevStall) begin
            checkOutput("hold w_en", bus.w_en, 1);
            checkOutput("hold w_addr", bus.w_addr, prevAddr);
            checkOutput("hold w_data", bus.w_data, prevData);
         end
         prevStall = bus.w_en && !bus.w_ready;
         prevAddr  = bus.w_addr;
         prevData  = bus.w_data;

         if (bus.start && !bus.busy && !bus.done) begin
            mBase         = bus.base;
            mShift        = int'(bus.shift);
            mIdx          = '0;
            jobAcc        = 0;
            firstStallAcc = -1;
         end
         if (bus.s_valid && bus.s_ready) begin
            e.addr = mBase + mIdx;
            e.data = quantModel(bus.s_sum, mShift);
            expQ.push_back(e);
            mIdx   = mIdx + 8'd1;
            jobAcc++;
         end
         if (bus.busy && !bus.s_ready && firstStallAcc < 0) begin
            firstStallAcc = jobAcc;
         end
         if (bus.w_en && bus.w_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected write addr", bus.w_addr, 8'hXX);
            end else begin
               e = expQ.pop_front();
               checkOutput("write addr", bus.w_addr, e.addr);
               checkOutput("write data", bus.w_data, e.data);
            end
            obsAddr.push_back(bus.w_addr);
            obsData.push_back(bus.w_data);
            wrCnt++;
         end
         if (bus.done) doneCnt++;
      end
   end

   // Advance to just after the next rising edge, releasing a pending stall.
   task automatic tick();
      @(posedge clk);
      #1;
      if (stallLeft > 0) begin
         stallLeft--;
         if (stallLeft == 0) bus.w_ready = 1'b1;
      end
   endtask

   task automatic setBeat(input int i, input int val, input bit f, input bit l);
      stimSum[i]   = val[21:0];
      stimFirst[i] = f;
      stimLast[i]  = l;
   endtask

   // Run one job: start, offer nBeats beats from the stimulus table, then
   // optionally wait for completion and check the job-level results.
   task automatic applyStimulus(input logic [7:0] b, input logic [10:0] sz, input logic [4:0] sh,
                                input int nBeats, input int stall, input bit waitDone);
      int d0, w0, lat, waitCnt;
      bit ok, eErr;
      d0   = doneCnt;
      w0   = wrCnt;
      eErr = 0;
      tick();
      bus.start = 1'b1;
      bus.base  = b;
      bus.size  = sz;
      bus.shift = sh;
      if (stall > 0) begin
         bus.w_ready = 1'b0;
         stallLeft   = stall;
      end
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < nBeats; i++) begin
         bus.s_sum   = stimSum[i];
         bus.s_first = stimFirst[i];
         bus.s_last  = stimLast[i];
         bus.s_valid = 1'b1;
         eErr |= (stimFirst[i] != (i == 0)) || (stimLast[i] != (i == int'(sz) - 1));
         ok      = 0;
         waitCnt = 0;
         while (!ok && waitCnt < 100) begin
            @(negedge clk);
            ok = bus.s_ready;
            tick();
            waitCnt++;
         end
         if (!ok) checkOutput("beat accept timeout", 0, 1);
      end
      bus.s_valid = 1'b0;
      bus.s_first = 1'b0;
      bus.s_last  = 1'b0;
      if (waitDone) begin
         lat = 0;
         while (doneCnt == d0 && lat < 300) begin
            @(negedge clk);
            #1;
            lat++;
            if (doneCnt == d0) tick();
         end
         lastLat = lat;
         tick();
         tick();
         checkOutput("done pulse count", doneCnt - d0, 1);
         checkOutput("busy after done", bus.busy, 0);
         checkOutput("err after job", bus.err, eErr);
         checkOutput("write count", wrCnt - w0, sz);
         checkOutput("pending writes", expQ.size(), 0);
      end
   endtask

   // Literal check of an observed write by its position in the write log.
   task automatic checkObs(input string name, input int idx, input logic [7:0] a, input logic [7:0] d);
      if (idx < obsData.size()) begin
         checkOutput({name, " addr"}, obsAddr[idx], a);
         checkOutput({name, " data"}, obsData[idx], d);
      end else begin
         checkOutput({name, " missing write"}, obsData.size(), idx + 1);
      end
   endtask

   // Directed job sequence.
   initial begin
      int o0;
      int w0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.base    = '0;
      bus.size    = '0;
      bus.shift   = '0;
      bus.s_sum   = '0;
      bus.s_valid = 1'b0;
      bus.s_first = 1'b0;
      bus.s_last  = 1'b0;
      bus.w_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset s_ready", bus.s_ready, 0);
      checkOutput("reset w_en", bus.w_en, 0);
      checkOutput("reset w_addr", bus.w_addr, 0);
      checkOutput("reset w_data", bus.w_data, 0);
      checkOutput("reset busy", bus.busy, 0);
      checkOutput("reset done", bus.done, 0);
      checkOutput("reset err", bus.err, 0);
      rst_n = 1'b1;

      // basic job: 100,-7,6 >> 2 with rounding
      setBeat(0, 100, 1, 0);
      setBeat(1, -7, 0, 0);
      setBeat(2, 6, 0, 1);
      o0 = obsData.size();
      applyStimulus(8'h10, 11'd3, 5'd2, 3, 0, 1);
      checkObs("basic w0", o0,     8'h10, 8'd25);
      checkObs("basic w1", o0 + 1, 8'h11, 8'hFE);
      checkObs("basic w2", o0 + 2, 8'h12, 8'd2);

      // saturation
      setBeat(0, 300, 1, 0);
      setBeat(1, -300, 0, 1);
      o0 = obsData.size();
      applyStimulus(8'h20, 11'd2, 5'd0, 2, 0, 1);
      checkObs("sat high", o0, 8'h20, 8'h7F);
`ifdef ACC_OUT_RELU_EN
      checkObs("sat low relu", o0 + 1, 8'h21, 8'h00);
`else
      checkObs("sat low", o0 + 1, 8'h21, 8'h80);
`endif

      // backpressure: RAM stalled for 10 cycles during an 8-beat job;
      // one beat sits in the write register and 4 fill the FIFO
      for (int i = 0; i < 8; i++) setBeat(i, i * 37 - 100, i == 0, i == 7);
      o0 = obsData.size();
      applyStimulus(8'h30, 11'd8, 5'd1, 8, 10, 1);
      checkOutput("beats before s_ready fell", firstStallAcc, 5);
      checkObs("bp first", o0,     8'h30, 8'hCE);
      checkObs("bp last",  o0 + 7, 8'h37, 8'h50);

      // address wrap
      for (int i = 0; i < 4; i++) setBeat(i, i + 1, i == 0, i == 3);
      o0 = obsData.size();
      applyStimulus(8'hFE, 11'd4, 5'd0, 4, 0, 1);
      checkObs("wrap w0", o0,     8'hFE, 8'd1);
      checkObs("wrap w1", o0 + 1, 8'hFF, 8'd2);
      checkObs("wrap w2", o0 + 2, 8'h00, 8'd3);
      checkObs("wrap w3", o0 + 3, 8'h01, 8'd4);

      // framing: s_last early on beat 1, job still runs all 3 beats
      setBeat(0, 5, 1, 0);
      setBeat(1, 6, 0, 1);
      setBeat(2, 7, 0, 1);
      applyStimulus(8'h50, 11'd3, 5'd0, 3, 0, 1);
      checkOutput("framing err literal", bus.err, 1);

      // zero-length job: done one cycle after start, err cleared by start
      applyStimulus(8'h60, 11'd0, 5'd0, 0, 0, 1);
      checkOutput("size0 done latency", lastLat, 1);

      // reset after 2 of 5 beats
      for (int i = 0; i < 5; i++) setBeat(i, 11 + i, i == 0, i == 4);
      applyStimulus(8'h70, 11'd5, 5'd0, 2, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset s_ready", bus.s_ready, 0);
      checkOutput("midreset w_en", bus.w_en, 0);
      checkOutput("midreset w_addr", bus.w_addr, 0);
      checkOutput("midreset w_data", bus.w_data, 0);
      checkOutput("midreset busy", bus.busy, 0);
      checkOutput("midreset done", bus.done, 0);
      checkOutput("midreset err", bus.err, 0);
      w0 = wrCnt;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick();
      checkOutput("no writes after reset", wrCnt - w0, 0);
      setBeat(0, 50, 1, 0);
      setBeat(1, -50, 0, 1);
      o0 = obsData.size();
      applyStimulus(8'h20, 11'd2, 5'd3, 2, 0, 1);
      checkObs("post reset w0", o0,     8'h20, 8'd6);
      checkObs("post reset w1", o0 + 1, 8'h21, 8'hFA);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
